// File: rtl/key_scheduler_if.sv
// -----------------------------------------------------------------------------
// key_scheduler_if
// Handshake bundle between a key-schedule requester/consumer and the AES-128
// key scheduler.
//   load_key   : request to start a schedule from cipher_key (requester -> scheduler)
//   cipher_key : 128-bit AES key, sampled only when a load is accepted
//   reverse    : order select sampled together with load_key
//   key_ready  : consumer accepts the presented round key
//   round_key  : current round key, word 0 in bits [127:96] (scheduler -> consumer)
//   round_num  : round index 0..10 of round_key
//   key_valid  : round_key/round_num are valid
//   busy       : schedule in progress
//   done       : one-cycle pulse after the final key is accepted
// Modports: master = requester/consumer side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface key_scheduler_if;
    logic         load_key;
    logic [127:0] cipher_key;
    logic         reverse;
    logic         key_ready;
    logic [127:0] round_key;
    logic [3:0]   round_num;
    logic         key_valid;
    logic         busy;
    logic         done;

    modport master (
        output load_key, cipher_key, reverse, key_ready,
        input  round_key, round_num, key_valid, busy, done
    );

    modport slave (
        input  load_key, cipher_key, reverse, key_ready,
        output round_key, round_num, key_valid, busy, done
    );
endinterface

// File: rtl/key_scheduler.sv
// -----------------------------------------------------------------------------
// key_scheduler
// AES-128 key expansion producing the eleven round keys one at a time over a
// valid/ready handshake. In forward order a new key is derived from the
// current one on every accepted transfer, giving one key per cycle.
//
// Optional feature (macro REVERSE_ORDER_EN): adds an 11 x 128-bit round-key
// store. With reverse=1 at load, all keys are expanded first (10 cycles,
// key_valid low) and then presented from round 10 down to round 0. Without
// the macro the reverse input is ignored and no store exists.
//
// Ports:
//   clk   : system clock, rising edge
//   n_rst : asynchronous active-low reset
//   ks    : key_scheduler_if.slave (load_key, cipher_key, reverse, key_ready,
//           round_key, round_num, key_valid, busy, done)
// -----------------------------------------------------------------------------
module key_scheduler (
    input  logic          clk,
    input  logic          n_rst,
    key_scheduler_if.slave ks
);

    typedef enum logic [1:0] {IDLE, EXPAND, EMIT, DONE} state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    state_t       state_reg;
    logic [127:0] key_reg;
    logic [3:0]   round_num_reg;
    logic         key_valid_reg;
    logic         busy_reg;
    logic         done_reg;

    // ------------------------------------------------------------------
    // Next round key derived combinationally from key_reg. The round
    // constant is indexed by the round number of the key being consumed.
    // ------------------------------------------------------------------
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [7:0]   rcon;
    logic [31:0]  w0_next, w1_next, w2_next, w3_next;
    logic [127:0] key_next;

    assign rot_word = {key_reg[23:0], key_reg[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sub_word
            assign sub_word[gi*8 +: 8] = SBOX[rot_word[gi*8 +: 8]];
        end
    endgenerate

    always_comb begin
        rcon = 8'h00;
        case (round_num_reg)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign w0_next  = key_reg[127:96] ^ sub_word ^ {rcon, 24'h000000};
    assign w1_next  = key_reg[95:64] ^ w0_next;
    assign w2_next  = key_reg[63:32] ^ w1_next;
    assign w3_next  = key_reg[31:0]  ^ w2_next;
    assign key_next = {w0_next, w1_next, w2_next, w3_next};

`ifdef REVERSE_ORDER_EN
    // ------------------------------------------------------------------
    // Round-key store: entry 0 is written at load, entries 1..10 during
    // EXPAND. After expansion key_reg already holds round 10, so the
    // store is only read when stepping down to rounds 9..0.
    // ------------------------------------------------------------------
    logic         rev_reg;
    logic [127:0] store_q [0:10];
    logic         store_we;
    logic [3:0]   store_idx;
    logic [127:0] store_d;

    always_comb begin
        store_we  = 1'b0;
        store_idx = 4'd0;
        store_d   = ks.cipher_key;
        if (state_reg == IDLE) begin
            store_we  = ks.load_key && ks.reverse;
            store_idx = 4'd0;
            store_d   = ks.cipher_key;
        end else if (state_reg == EXPAND) begin
            store_we  = 1'b1;
            store_idx = round_num_reg + 4'd1;
            store_d   = key_next;
        end
    end

    generate
        for (gi = 0; gi < 11; gi++) begin : g_store
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    store_q[gi] <= '0;
                end else if (store_we && (store_idx == 4'(gi))) begin
                    store_q[gi] <= store_d;
                end
            end
        end
    endgenerate
`else
    // Order select has no effect in this build.
    logic unused_reverse;
    assign unused_reverse = ks.reverse;
`endif

    // ------------------------------------------------------------------
    // Control FSM; all outputs are registered.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg     <= IDLE;
            key_reg       <= '0;
            round_num_reg <= '0;
            key_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
`ifdef REVERSE_ORDER_EN
            rev_reg       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (ks.load_key) begin
                        key_reg       <= ks.cipher_key;
                        round_num_reg <= 4'd0;
                        busy_reg      <= 1'b1;
`ifdef REVERSE_ORDER_EN
                        rev_reg <= ks.reverse;
                        if (ks.reverse) begin
                            state_reg <= EXPAND;
                        end else begin
                            state_reg     <= EMIT;
                            key_valid_reg <= 1'b1;
                        end
`else
                        state_reg     <= EMIT;
                        key_valid_reg <= 1'b1;
`endif
                    end
                end

                EXPAND: begin
`ifdef REVERSE_ORDER_EN
                    key_reg       <= key_next;
                    round_num_reg <= round_num_reg + 4'd1;
                    if (round_num_reg == 4'd9) begin
                        state_reg     <= EMIT;
                        key_valid_reg <= 1'b1;
                    end
`else
                    state_reg <= IDLE;
`endif
                end

                EMIT: begin
                    if (key_valid_reg && ks.key_ready) begin
`ifdef REVERSE_ORDER_EN
                        if (rev_reg) begin
                            if (round_num_reg == 4'd0) begin
                                state_reg     <= DONE;
                                key_valid_reg <= 1'b0;
                                busy_reg      <= 1'b0;
                                done_reg      <= 1'b1;
                            end else begin
                                key_reg       <= store_q[round_num_reg - 4'd1];
                                round_num_reg <= round_num_reg - 4'd1;
                            end
                        end else
`endif
                        if (round_num_reg == 4'd10) begin
                            state_reg     <= DONE;
                            key_valid_reg <= 1'b0;
                            busy_reg      <= 1'b0;
                            done_reg      <= 1'b1;
                        end else begin
                            key_reg       <= key_next;
                            round_num_reg <= round_num_reg + 4'd1;
                        end
                    end
                end

                DONE: begin
                    // Any load_key seen here is deliberately dropped.
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ks.round_key = key_reg;
    assign ks.round_num = round_num_reg;
    assign ks.key_valid = key_valid_reg;
    assign ks.busy      = busy_reg;
    assign ks.done      = done_reg;

endmodule

// File: tb/tb_key_scheduler.sv
// -----------------------------------------------------------------------------
// tb_key_scheduler
// Directed bench for key_scheduler: reset state, forward FIPS-197 schedule,
// backpressure, ignored loads, reset mid-schedule, and the reverse select
// (reverse order when REVERSE_ORDER_EN is defined, forward order otherwise).
// -----------------------------------------------------------------------------
module tb_key_scheduler;

    logic clk = 1'b0;
    logic n_rst;

    always #5 clk = ~clk;

    key_scheduler_if ks_if ();

    key_scheduler dut (
        .clk   (clk),
        .n_rst (n_rst),
        .ks    (ks_if)
    );

    int checks = 0;
    int errors = 0;

    logic [127:0] fips [0:10];
    logic [127:0] key_a;
    logic [127:0] key_b;
    logic [127:0] key_b_r1;
    logic [127:0] key_b_r10;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_key(input string tag, input int r, input logic [127:0] key);
        chk($sformatf("%s_valid_r%0d", tag, r), 128'(ks_if.key_valid), 128'd1);
        chk($sformatf("%s_num_r%0d", tag, r), 128'(ks_if.round_num), 128'(r));
        chk($sformatf("%s_key_r%0d", tag, r), ks_if.round_key, key);
        $display("%s: round %0d key %h ready %0d", tag, ks_if.round_num, ks_if.round_key, ks_if.key_ready);
    endtask

    task automatic chk_done_pulse(input string tag);
        chk({tag, "_done"}, 128'(ks_if.done), 128'd1);
        chk({tag, "_valid_low"}, 128'(ks_if.key_valid), 128'd0);
        chk({tag, "_busy_low"}, 128'(ks_if.busy), 128'd0);
        tick();
        chk({tag, "_done_clear"}, 128'(ks_if.done), 128'd0);
    endtask

    task automatic do_load(input logic [127:0] key, input logic rev);
        ks_if.cipher_key = key;
        ks_if.reverse    = rev;
        ks_if.load_key   = 1'b1;
        tick();
        ks_if.load_key   = 1'b0;
        ks_if.reverse    = 1'b0;
        ks_if.cipher_key = '1;   // must not matter after acceptance
        $display("load accepted: key %h reverse %0d", key, rev);
    endtask

    initial begin
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        key_a     = fips[0];
        key_b     = 128'h000102030405060708090a0b0c0d0e0f;
        key_b_r1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        key_b_r10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

        // Reset state
        n_rst              = 1'b0;
        ks_if.load_key     = 1'b0;
        ks_if.cipher_key   = '0;
        ks_if.reverse      = 1'b0;
        ks_if.key_ready    = 1'b1;   // ready with nothing valid must be harmless
        repeat (2) @(posedge clk);
        #1;
        chk("rst_key", ks_if.round_key, 128'd0);
        chk("rst_num", 128'(ks_if.round_num), 128'd0);
        chk("rst_valid", 128'(ks_if.key_valid), 128'd0);
        chk("rst_busy", 128'(ks_if.busy), 128'd0);
        chk("rst_done", 128'(ks_if.done), 128'd0);
        n_rst = 1'b1;
        tick();
        chk("idle_valid", 128'(ks_if.key_valid), 128'd0);

        // Forward schedule, full throughput
        do_load(key_a, 1'b0);
        for (int r = 0; r <= 10; r++) begin
            expect_key("fwd", r, fips[r]);
            chk($sformatf("fwd_busy_r%0d", r), 128'(ks_if.busy), 128'd1);
            tick();
        end
        chk_done_pulse("fwd");

        // Backpressure: three stalled cycles at round 4
        do_load(key_a, 1'b0);
        for (int r = 0; r <= 10; r++) begin
            expect_key("bp", r, fips[r]);
            if (r == 4) begin
                ks_if.key_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    expect_key("bp_hold", 4, fips[4]);
                    chk($sformatf("bp_hold_done_%0d", s), 128'(ks_if.done), 128'd0);
                end
                ks_if.key_ready = 1'b1;
            end
            tick();
        end
        chk_done_pulse("bp");

        // Load while busy (round 5) and load during DONE are both ignored
        do_load(key_a, 1'b0);
        for (int r = 0; r <= 10; r++) begin
            expect_key("ign", r, fips[r]);
            if (r == 5) begin
                ks_if.cipher_key = '0;
                ks_if.load_key   = 1'b1;
            end
            tick();
            ks_if.load_key = 1'b0;
        end
        chk("ign_done", 128'(ks_if.done), 128'd1);
        ks_if.cipher_key = key_b;
        ks_if.load_key   = 1'b1;
        tick();
        ks_if.load_key = 1'b0;
        chk("ign_done_load_valid", 128'(ks_if.key_valid), 128'd0);
        chk("ign_done_load_busy", 128'(ks_if.busy), 128'd0);
        tick();
        chk("ign_idle_valid", 128'(ks_if.key_valid), 128'd0);

        // Reset at round 6, then a fresh key on the first edge after release
        do_load(key_a, 1'b0);
        for (int r = 0; r <= 6; r++) begin
            expect_key("mid", r, fips[r]);
            if (r < 6) tick();
        end
        n_rst = 1'b0;
        #1;
        chk("mrst_key", ks_if.round_key, 128'd0);
        chk("mrst_num", 128'(ks_if.round_num), 128'd0);
        chk("mrst_valid", 128'(ks_if.key_valid), 128'd0);
        chk("mrst_busy", 128'(ks_if.busy), 128'd0);
        chk("mrst_done", 128'(ks_if.done), 128'd0);
        @(negedge clk);
        n_rst = 1'b1;
        do_load(key_b, 1'b0);
        expect_key("new", 0, key_b);
        tick();
        expect_key("new", 1, key_b_r1);
        repeat (9) tick();
        expect_key("new", 10, key_b_r10);
        tick();
        chk_done_pulse("new");

        // Reverse select
        do_load(key_a, 1'b1);
`ifdef REVERSE_ORDER_EN
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("exp_valid_%0d", i), 128'(ks_if.key_valid), 128'd0);
            chk($sformatf("exp_busy_%0d", i), 128'(ks_if.busy), 128'd1);
            tick();
        end
        for (int r = 10; r >= 0; r--) begin
            expect_key("rev", r, fips[r]);
            tick();
        end
        chk_done_pulse("rev");
`else
        for (int r = 0; r <= 10; r++) begin
            expect_key("revoff", r, fips[r]);
            tick();
        end
        chk_done_pulse("revoff");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_scheduler.md
KEY_SCHEDULER -- requirements
Module: key_scheduler

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port n_rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port load_key  input  1  single-cycle request to start a schedule from cipher_key.
REQ-004 SHALL have port cipher_key  input  128  AES-128 cipher key, sampled only when load_key is accepted.
REQ-005 SHALL have port reverse  input  1  order select sampled with load_key; effective only under REVERSE_ORDER_EN.
REQ-006 SHALL have port key_ready  input  1  consumer (round stage) accepts the current round_key.
REQ-007 SHALL have port round_key  output  128  current AES-128 round key, word 0 in bits [127:96].
REQ-008 SHALL have port round_num  output  4  index 0..10 of round_key.
REQ-009 SHALL have port key_valid  output  1  round_key/round_num valid.
REQ-010 SHALL have port busy  output  1  high from load acceptance until last key accepted.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the final key is accepted.

Function
REQ-012 SHALL implement FSM states IDLE, EXPAND, EMIT, DONE.
REQ-013 IDLE: load_key=1 SHALL register cipher_key as round key 0 and enter EMIT (forward) or EXPAND (reverse, when enabled) next cycle.
REQ-014 Forward: key_valid SHALL rise the cycle after load acceptance with round_num=0, round_key=cipher_key.
REQ-015 A transfer SHALL occur only on key_valid&&key_ready; round_key/round_num SHALL hold stable while key_valid&&!key_ready.
REQ-016 On each forward transfer with round_num<10, next key SHALL be registered and presented the following cycle (one key per cycle at key_ready=1 throughput).
REQ-017 Next key SHALL follow FIPS-197: w0'=w0^SubWord(RotWord(w3))^Rcon[i], w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'; Rcon = 01,02,04,08,10,20,40,80,1B,36 in the MSB byte.
REQ-018 SubWord SHALL use the standard AES S-box on four bytes, combinationally.
REQ-019 Transfer of round_num=10 SHALL move to DONE: key_valid=0, busy=0 and done=1 for exactly one cycle, then IDLE.
REQ-020 load_key while busy SHALL be ignored; load_key in DONE SHALL be ignored.
REQ-021 key_ready while key_valid=0 SHALL have no effect.

Reset
REQ-022 n_rst=0 SHALL immediately force IDLE, round_key=0, round_num=0, key_valid=0, busy=0, done=0, and clear internal key storage.
REQ-023 Reset asserted mid-schedule SHALL abandon the schedule; after release the block SHALL accept a new load_key on the first rising edge.

Configuration
REQ-024 Macro REVERSE_ORDER_EN SHALL, when defined, add an 11-entry x 128-bit round-key store and enable reverse.
REQ-025 With REVERSE_ORDER_EN and reverse=1 at load: EXPAND SHALL compute keys 1..10 one per cycle (10 cycles, key_valid=0, busy=1), then EMIT keys round_num 10 down to 0 under REQ-015; DONE follows transfer of round_num=0.
REQ-026 With REVERSE_ORDER_EN and reverse=0, behaviour SHALL be identical to the forward mode of REQ-014..REQ-019.
REQ-027 Without REVERSE_ORDER_EN, reverse SHALL be ignored, no key store SHALL be synthesized, and order SHALL always be 0..10.

Verification
REQ-028 Forward FIPS-197: cipher_key=2b7e151628aed2a6abf7158809cf4f3c, key_ready=1 -> round 0 = cipher_key one cycle after load, round 1=a0fafe1788542cb123a339392a6c7605, round 10=d014f9a8c9ee2589e13f0cc8b6630ca6 on cycle 11, done pulse on cycle 12.
REQ-029 Backpressure: same key, key_ready low for 3 cycles at round_num=4 -> round_key/round_num held for 3 cycles, sequence values unchanged, done delayed by 3 cycles.
REQ-030 Ignored load: load_key with cipher_key=0 at round_num=5 -> sequence continues with original key values, no restart.
REQ-031 Reset mid-operation: n_rst low at round_num=6 -> all outputs 0 same cycle; new load after release -> round 0 = new cipher_key next cycle.
REQ-032 REVERSE_ORDER_EN, reverse=1, FIPS-197 key -> key_valid low 10 cycles, then first key d014f9a8c9ee2589e13f0cc8b6630ca6 with round_num=10, last key 2b7e151628aed2a6abf7158809cf4f3c with round_num=0, then done.
REQ-033 Without REVERSE_ORDER_EN, reverse=1 -> output identical to REQ-028.
